pinwheel_operand_fetch: RTL and testbench

Operand-fetch stage directly upstream of the banked, threaded register file. It accepts decoded instructions tagged with a thread id and forms the register-file read addresses as {thread, rs}. The register file has one-cycle registered reads with read-before-write behaviour, so this stage captures rdata a cycle later and forwards in-flight writeback data. It then presents fully resolved rs1/rs2 operands to execute over a valid/ready handshake.

---
 rtl/pinwheel_pkg.sv | 28 ++
 rtl/pinwheel_operand_bypass.sv | 27 ++
 rtl/pinwheel_operand_fetch.sv | 159 +++++++++++++++
 tb/tb_pinwheel_operand_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pinwheel_pkg.sv
// Shared types and helpers for the pinwheel operand-fetch stage and its threaded register file.
package pinwheel_pkg;

    localparam int unsigned reg_count    = 32;
    localparam int unsigned thread_count = 4;
    localparam int unsigned thread_bits  = $clog2(thread_count);
    localparam int unsigned word_bits    = 32;
    localparam int unsigned idx_bits     = 5;
    localparam int unsigned addr_bits    = $clog2(reg_count * thread_count);

    typedef logic [idx_bits-1:0]    reg_idx_t;
    typedef logic [thread_bits-1:0] thread_t;
    typedef logic [addr_bits-1:0]   rf_addr_t;
    typedef logic [word_bits-1:0]   word_t;

    typedef struct packed {
        thread_t     thread;
        reg_idx_t    rs1;
        reg_idx_t    rs2;
        logic [31:0] insn;
        logic [31:0] pc;
    } fetch_req_t;

    function automatic rf_addr_t rf_addr(input thread_t thread, input reg_idx_t idx);
        return {thread, idx};
    endfunction

endpackage

// File: rtl/pinwheel_operand_bypass.sv
// Operand resolve mux: x0, current writeback, last-cycle writeback, then register-file read data.
module pinwheel_operand_bypass
    import pinwheel_pkg::*;
(
    input  rf_addr_t src_addr,
    input  logic     wb_wren,
    input  rf_addr_t wb_waddr,
    input  word_t    wb_wdata,
    input  logic     bp_valid,
    input  rf_addr_t bp_addr,
    input  word_t    bp_data,
    input  word_t    rf_rdata,
    output word_t    operand_c
);

    always_comb begin
        operand_c = rf_rdata;
        if (src_addr[idx_bits-1:0] == '0) begin
            operand_c = '0;
        end else if (wb_wren && (wb_waddr == src_addr)) begin
            operand_c = wb_wdata;
        end else if (bp_valid && (bp_addr == src_addr)) begin
            operand_c = bp_data;
        end
    end

endmodule

// File: rtl/pinwheel_operand_fetch.sv
// Operand fetch: issues threaded RF reads, bypasses writebacks, presents resolved operands.
// Optional PINWHEEL_OPFETCH_PERF_EN adds stall_cycles/issued counters.
module pinwheel_operand_fetch
    import pinwheel_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  thread_t     in_thread,
    input  reg_idx_t    in_rs1,
    input  reg_idx_t    in_rs2,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_pc,
    output rf_addr_t    rf_raddr0,
    output rf_addr_t    rf_raddr1,
    input  word_t       rf_rdata0,
    input  word_t       rf_rdata1,
    input  logic        wb_wren,
    input  rf_addr_t    wb_waddr,
    input  word_t       wb_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output thread_t     out_thread,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc,
    output word_t       out_rs1_data,
    output word_t       out_rs2_data
`ifdef PINWHEEL_OPFETCH_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] issued
`endif
);

    fetch_req_t s1;
    fetch_req_t in_req;
    logic       s1_valid;
    reg_idx_t   s2_rs1;
    reg_idx_t   s2_rs2;
    logic       bp_valid;
    rf_addr_t   bp_addr;
    word_t      bp_data;
    logic       accept;
    logic       s2_free;
    logic       s1_adv;
    logic       snoop1;
    logic       snoop2;
    rf_addr_t   s1_addr1;
    rf_addr_t   s1_addr2;
    word_t      opnd1_c;
    word_t      opnd2_c;

    assign in_req = '{thread: in_thread, rs1: in_rs1, rs2: in_rs2, insn: in_insn, pc: in_pc};

    // Handshake, read addressing (held on stall) and S2 snoop detection.
    always_comb begin
        s2_free   = !out_valid || out_ready;
        s1_adv    = s1_valid && s2_free;
        in_ready  = !rst && (!s1_valid || s1_adv);
        accept    = in_valid && in_ready;
        s1_addr1  = rf_addr(s1.thread, s1.rs1);
        s1_addr2  = rf_addr(s1.thread, s1.rs2);
        rf_raddr0 = accept ? rf_addr(in_thread, in_rs1) : s1_addr1;
        rf_raddr1 = accept ? rf_addr(in_thread, in_rs2) : s1_addr2;
        snoop1    = out_valid && !out_ready && wb_wren && (s2_rs1 != '0)
                    && (wb_waddr == rf_addr(out_thread, s2_rs1));
        snoop2    = out_valid && !out_ready && wb_wren && (s2_rs2 != '0)
                    && (wb_waddr == rf_addr(out_thread, s2_rs2));
    end

    pinwheel_operand_bypass u_bypass1 (
        .src_addr (s1_addr1),
        .wb_wren  (wb_wren),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .bp_valid (bp_valid),
        .bp_addr  (bp_addr),
        .bp_data  (bp_data),
        .rf_rdata (rf_rdata0),
        .operand_c(opnd1_c)
    );

    pinwheel_operand_bypass u_bypass2 (
        .src_addr (s1_addr2),
        .wb_wren  (wb_wren),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .bp_valid (bp_valid),
        .bp_addr  (bp_addr),
        .bp_data  (bp_data),
        .rf_rdata (rf_rdata1),
        .operand_c(opnd2_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1       <= in_req;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Last-cycle write, covering the stale read-before-write result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_valid <= 1'b0;
            bp_addr  <= '0;
            bp_data  <= '0;
        end else begin
            bp_valid <= wb_wren && (wb_waddr[idx_bits-1:0] != '0);
            bp_addr  <= wb_waddr;
            bp_data  <= wb_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_thread   <= '0;
            out_insn     <= '0;
            out_pc       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            s2_rs1       <= '0;
            s2_rs2       <= '0;
        end else if (s1_adv) begin
            out_valid    <= 1'b1;
            out_thread   <= s1.thread;
            out_insn     <= s1.insn;
            out_pc       <= s1.pc;
            out_rs1_data <= opnd1_c;
            out_rs2_data <= opnd2_c;
            s2_rs1       <= s1.rs1;
            s2_rs2       <= s1.rs2;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (snoop1) out_rs1_data <= wb_wdata;
            if (snoop2) out_rs2_data <= wb_wdata;
        end
    end

`ifdef PINWHEEL_OPFETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            issued       <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cycles <= stall_cycles + 32'd1;
            if (out_valid && out_ready)  issued       <= issued + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pinwheel_operand_fetch.sv
// Bench for pinwheel_operand_fetch with a read-before-write register-file model.
module tb_pinwheel_operand_fetch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_thread;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_insn;
    logic [31:0] in_pc;
    logic [6:0]  rf_raddr0;
    logic [6:0]  rf_raddr1;
    logic [31:0] rf_rdata0;
    logic [31:0] rf_rdata1;
    logic        wb_wren;
    logic [6:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_thread;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
`ifdef PINWHEEL_OPFETCH_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] issued;
`endif

    int passed = 0;
    int total  = 0;

    logic [31:0] rf_mem [128];

    pinwheel_operand_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_thread   (in_thread),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_insn     (in_insn),
        .in_pc       (in_pc),
        .rf_raddr0   (rf_raddr0),
        .rf_raddr1   (rf_raddr1),
        .rf_rdata0   (rf_rdata0),
        .rf_rdata1   (rf_rdata1),
        .wb_wren     (wb_wren),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_thread  (out_thread),
        .out_insn    (out_insn),
        .out_pc      (out_pc),
        .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data)
`ifdef PINWHEEL_OPFETCH_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .issued      (issued)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered read returns the pre-write contents on a same-cycle write.
    always @(posedge clk) begin
        rf_rdata0 <= rf_mem[rf_raddr0];
        rf_rdata1 <= rf_mem[rf_raddr1];
        if (wb_wren) rf_mem[wb_waddr] <= wb_wdata;
    end

    typedef struct {
        logic [1:0]  thread;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive_in(input logic v, input logic [1:0] t, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [31:0] pc);
        in_valid  = v;
        in_thread = t;
        in_rs1    = r1;
        in_rs2    = r2;
        in_pc     = pc;
        in_insn   = pc ^ 32'h5A5A_0000;
    endtask

    task automatic drive_wb(input logic en, input logic [6:0] a, input logic [31:0] d);
        wb_wren  = en;
        wb_waddr = a;
        wb_wdata = d;
    endtask

    initial begin
        vecs[0] = '{2'd2, 5'd5,  5'd0,  32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{2'd1, 5'd4,  5'd3,  32'hC0DE0024, 32'hC0DE0023};
        vecs[2] = '{2'd3, 5'd4,  5'd31, 32'h44444444, 32'hC0DE007F};
        vecs[3] = '{2'd1, 5'd4,  5'd4,  32'hC0DE0024, 32'hC0DE0024};
        vecs[4] = '{2'd0, 5'd0,  5'd1,  32'h00000000, 32'hC0DE0001};
        vecs[5] = '{2'd0, 5'd31, 5'd0,  32'hC0DE001F, 32'h00000000};
        vecs[6] = '{2'd2, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[7] = '{2'd3, 5'd0,  5'd4,  32'h00000000, 32'h44444444};

        rst = 1'b1;
        out_ready = 1'b1;
        drive_in(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
        drive_wb(1'b0, 7'd0, 32'd0);
        #2;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        check("reset_out_pc", out_pc, 32'd0);
        check("reset_raddr0", 32'(rf_raddr0), 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Preload: every register gets C0DE0000|addr except a few specials.
        for (int a = 0; a < 128; a++) begin
            if (a == 'h45)      drive_wb(1'b1, 7'(a), 32'hDEADBEEF);
            else if (a == 'h64) drive_wb(1'b1, 7'(a), 32'h44444444);
            else if (a == 0)    drive_wb(1'b1, 7'(a), 32'h000000FF);
            else                drive_wb(1'b1, 7'(a), 32'hC0DE0000 | 32'(a));
            tick();
        end
        drive_wb(1'b0, 7'd0, 32'd0);
        tick();
        tick();

        // Back-to-back stream: outputs on consecutive cycles, one cycle after acceptance.
        for (int c = 0; c < 11; c++) begin
            if (c < 8) drive_in(1'b1, vecs[c].thread, vecs[c].rs1, vecs[c].rs2, 32'h1000 + 32'(c) * 4);
            else       drive_in(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
            #1;
            if (c < 8) check($sformatf("b2b_in_ready[%0d]", c), 32'(in_ready), 32'd1);
            tick();
            check($sformatf("b2b_out_valid[%0d]", c), 32'(out_valid), 32'((c >= 1) && (c <= 8)));
            if (c >= 1 && c <= 8) begin
                check($sformatf("b2b_thread[%0d]", c - 1), 32'(out_thread), 32'(vecs[c-1].thread));
                check($sformatf("b2b_pc[%0d]", c - 1), out_pc, 32'h1000 + 32'(c - 1) * 4);
                check($sformatf("b2b_insn[%0d]", c - 1), out_insn, (32'h1000 + 32'(c - 1) * 4) ^ 32'h5A5A_0000);
                check($sformatf("b2b_rs1[%0d]", c - 1), out_rs1_data, vecs[c-1].exp1);
                check($sformatf("b2b_rs2[%0d]", c - 1), out_rs2_data, vecs[c-1].exp2);
            end
        end

        // Write in the accept cycle: RF returns the old value, bypass register must win.
        drive_in(1'b1, 2'd1, 5'd3, 5'd0, 32'h2000);
        drive_wb(1'b1, 7'(32 + 3), 32'h1234);
        tick();
        drive_in(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
        drive_wb(1'b0, 7'd0, 32'd0);
        tick();
        check("rbw_valid", 32'(out_valid), 32'd1);
        check("rbw_rs1", out_rs1_data, 32'h1234);
        check("rbw_rs2", out_rs2_data, 32'h0);
        tick();
        check("rbw_drain", 32'(out_valid), 32'd0);

        // Write in the resolve cycle: current-write path.
        drive_in(1'b1, 2'd1, 5'd6, 5'd0, 32'h2004);
        tick();
        drive_in(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
        drive_wb(1'b1, 7'(32 + 6), 32'h1234);
        tick();
        drive_wb(1'b0, 7'd0, 32'd0);
        check("curwr_rs1", out_rs1_data, 32'h1234);
        tick();

        // Backpressure with both slots full, plus S2 snoop of a write to t0 r7.
        out_ready = 1'b0;
        drive_in(1'b1, 2'd0, 5'd1, 5'd7, 32'h3000);
        tick();
        drive_in(1'b1, 2'd0, 5'd7, 5'd2, 32'h3004);
        tick();
        drive_in(1'b1, 2'd1, 5'd9, 5'd9, 32'h3008);
        drive_wb(1'b1, 7'd7, 32'hAA);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_raddr0", 32'(rf_raddr0), 32'd7);
        check("bp_raddr1", 32'(rf_raddr1), 32'd2);
        tick();
        drive_wb(1'b0, 7'd0, 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_pc", out_pc, 32'h3000);
        check("bp_rs1", out_rs1_data, 32'hC0DE0001);
        check("bp_snoop_rs2", out_rs2_data, 32'hAA);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold_ready[%0d]", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_hold_raddr0[%0d]", i), 32'(rf_raddr0), 32'd7);
            tick();
            check($sformatf("bp_hold_pc[%0d]", i), out_pc, 32'h3000);
            check($sformatf("bp_hold_rs2[%0d]", i), out_rs2_data, 32'hAA);
        end
        out_ready = 1'b1;
        drive_in(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_rel_valid", 32'(out_valid), 32'd1);
        check("bp_rel_pc", out_pc, 32'h3004);
        check("bp_rel_rs1", out_rs1_data, 32'hAA);
        check("bp_rel_rs2", out_rs2_data, 32'hC0DE0002);
        tick();
        check("bp_rel_drain", 32'(out_valid), 32'd0);

        // Reset while stalled with both slots full.
        out_ready = 1'b0;
        drive_in(1'b1, 2'd2, 5'd5, 5'd0, 32'h4000);
        tick();
        drive_in(1'b1, 2'd3, 5'd4, 5'd0, 32'h4004);
        tick();
        drive_in(1'b1, 2'd1, 5'd1, 5'd1, 32'h4008);
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_in_ready", 32'(in_ready), 32'd0);
        check("rst_async_rs1", out_rs1_data, 32'd0);
        check("rst_async_raddr0", 32'(rf_raddr0), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        drive_in(1'b1, 2'd2, 5'd5, 5'd31, 32'h5000);
        tick();
        drive_in(1'b0, 2'd0, 5'd0, 5'd0, 32'd0);
        check("rst_lat_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("rst_after_valid", 32'(out_valid), 32'd1);
        check("rst_after_thread", 32'(out_thread), 32'd2);
        check("rst_after_pc", out_pc, 32'h5000);
        check("rst_after_rs1", out_rs1_data, 32'hDEADBEEF);
        check("rst_after_rs2", out_rs2_data, 32'hC0DE005F);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
